// File: rtl/mem_stage_dual_pkg.sv
// Shared widths, load-type codes, stall bit positions and slot layouts for the dual-issue MEM stage.
package mem_stage_dual_pkg;

    localparam int HILO_WD     = 66;
    localparam int SLOT_IN_WD  = 144;
    localparam int SLOT_OUT_WD = 136;
    localparam int RF_FWD_WD   = 38;

    localparam int EX_TO_MEM_WD = 2 * SLOT_IN_WD;
    localparam int MEM_TO_WB_WD = 2 * SLOT_OUT_WD;
    localparam int MEM_TO_RF_WD = 2 * RF_FWD_WD;

    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    typedef struct packed {
        logic [HILO_WD-1:0] hilo;
        logic [31:0]        pc;
        logic               ram_en;
        logic [3:0]         ram_wen;
        logic [2:0]         ld_type;
        logic               rf_we;
        logic [4:0]         rf_waddr;
        logic [31:0]        ex_result;
    } slot_in_t;

    typedef struct packed {
        logic [HILO_WD-1:0] hilo;
        logic [31:0]        pc;
        logic               rf_we;
        logic [4:0]         rf_waddr;
        logic [31:0]        rf_wdata;
    } slot_out_t;

    typedef enum logic {
        LD_LIVE = 1'b0,
        LD_HELD = 1'b1
    } ld_hold_state_t;

    // A slot is a load when it touches memory without any byte write enable.
    function automatic logic is_load(input slot_in_t s);
        return s.ram_en && (s.ram_wen == 4'b0000);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects and extends the addressed byte/halfword of a little-endian SRAM word.
module mem_load_align
    import mem_stage_dual_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_type,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Reserved encodings fall through to a full word.
    always_comb begin
        result = rdata;
        case (ld_type)
            LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  result = {24'h000000, byte_sel};
            LD_LH:   result = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  result = {16'h0000, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_dual.sv
// Dual-issue MEM stage: EX->MEM register, load alignment with stall-safe data hold, WB and forwarding buses.
module mem_stage_dual
    import mem_stage_dual_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

    logic [EX_TO_MEM_WD-1:0] mem_reg;
    logic                    reg_bubble;
    logic                    reg_load;
    logic                    reg_update;

    ld_hold_state_t ld_state;
    logic [31:0]    hold_q;

    slot_in_t  i1_in;
    slot_in_t  i2_in;
    slot_out_t i1_out;
    slot_out_t i2_out;

    logic        i1_load;
    logic [31:0] load_data;
    logic [31:0] load_result;

    assign reg_bubble = stall[STALL_MEM] & ~stall[STALL_WB];
    assign reg_load   = ~stall[STALL_MEM];
    assign reg_update = rst | flush | reg_bubble | reg_load;

    // Reset, flush and bubble all clear the register; flush outranks any stall.
    always_ff @(posedge clk) begin
        if (rst || flush || reg_bubble) begin
            mem_reg <= '0;
        end else if (reg_load) begin
            mem_reg <= ex_to_mem_bus;
        end
    end

    assign i1_in   = slot_in_t'(mem_reg[SLOT_IN_WD-1:0]);
    assign i2_in   = slot_in_t'(mem_reg[EX_TO_MEM_WD-1:SLOT_IN_WD]);
    assign i1_load = is_load(i1_in);

    // The SRAM only presents read data for one cycle, so a load frozen in MEM latches it once.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state <= LD_LIVE;
            hold_q   <= '0;
        end else begin
            case (ld_state)
                LD_LIVE: begin
                    if (!reg_update && i1_load) begin
                        ld_state <= LD_HELD;
                        hold_q   <= data_sram_rdata;
                    end
                end
                LD_HELD: begin
                    if (reg_update) begin
                        ld_state <= LD_LIVE;
                    end
                end
                default: ld_state <= LD_LIVE;
            endcase
        end
    end

    assign load_data = (ld_state == LD_HELD) ? hold_q : data_sram_rdata;

    mem_load_align u_load_align (
        .rdata   (load_data),
        .addr_lo (i1_in.ex_result[1:0]),
        .ld_type (i1_in.ld_type),
        .result  (load_result)
    );

    always_comb begin
        i1_out          = '0;
        i1_out.hilo     = i1_in.hilo;
        i1_out.pc       = i1_in.pc;
        i1_out.rf_we    = i1_in.rf_we;
        i1_out.rf_waddr = i1_in.rf_waddr;
        i1_out.rf_wdata = i1_load ? load_result : i1_in.ex_result;
    end

    // Slot i2 never carries a memory op, so it passes straight through.
    always_comb begin
        i2_out          = '0;
        i2_out.hilo     = i2_in.hilo;
        i2_out.pc       = i2_in.pc;
        i2_out.rf_we    = i2_in.rf_we;
        i2_out.rf_waddr = i2_in.rf_waddr;
        i2_out.rf_wdata = i2_in.ex_result;
    end

    assign mem_to_wb_bus = {i2_out, i1_out};
    assign mem_to_rf_bus = {i2_out.rf_we, i2_out.rf_waddr, i2_out.rf_wdata,
                            i1_out.rf_we, i1_out.rf_waddr, i1_out.rf_wdata};

    logic unused_ok;
    assign unused_ok = ^{i2_in.ram_en, i2_in.ram_wen, i2_in.ld_type,
                         stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage_dual.sv
// Self-checking bench for mem_stage_dual: directed scenarios plus randomized traffic against a field-level model.
module tb_mem_stage_dual;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [5:0]   stall;
    logic [287:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [271:0] mem_to_wb_bus;
    logic [75:0]  mem_to_rf_bus;

    int vectorCount = 0;
    int missCount   = 0;

    // Model state: what the MEM register holds, and whether its load data is frozen.
    logic [287:0] m_reg;
    bit           m_held;
    logic [31:0]  m_hold;

    mem_stage_dual dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_rf_bus   (mem_to_rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [271:0] actual, input logic [271:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [143:0] make_slot(input logic [65:0] hilo, input logic [31:0] pc,
                                               input logic ram_en, input logic [3:0] wen,
                                               input logic [2:0] ld, input logic we,
                                               input logic [4:0] waddr, input logic [31:0] res);
        return {hilo, pc, ram_en, wen, ld, we, waddr, res};
    endfunction

    function automatic logic [143:0] rand_slot();
        logic [3:0] wen;
        wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        return make_slot({2'($urandom), $urandom, $urandom}, $urandom, 1'($urandom),
                         wen, 3'($urandom), 1'($urandom), 5'($urandom), $urandom);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] a, input logic [2:0] t);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a)) & 32'hFF;
        h = (d >> (16 * a[1])) & 32'hFFFF;
        case (t)
            3'd1:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return h;
            default: return d;
        endcase
    endfunction

    function automatic logic [135:0] ref_out_slot(input logic [143:0] s, input bit mem_slot, input logic [31:0] ldata);
        logic [31:0] wdata;
        bit          is_ld;
        is_ld = mem_slot && s[45] && (s[44:41] == 4'h0);
        wdata = is_ld ? ref_load(ldata, s[1:0], s[40:38]) : s[31:0];
        return {s[143:78], s[77:46], s[37], s[36:32], wdata};
    endfunction

    task automatic applyStimulus(input logic [287:0] bus, input logic [5:0] st, input logic fl,
                                 input logic rs, input logic [31:0] rdata_next);
        bit          upd;
        logic [31:0] ldata;
        logic [135:0] o1;
        logic [135:0] o2;
        ex_to_mem_bus = bus;
        stall         = st;
        flush         = fl;
        rst           = rs;
        @(posedge clk);
        upd = rs || fl || !st[3] || (st[3] && !st[4]);
        if (!upd && !m_held && m_reg[45] && (m_reg[44:41] == 4'h0)) begin
            m_held = 1'b1;
            m_hold = data_sram_rdata;
        end
        if (upd) m_held = 1'b0;
        if (rs || fl || (st[3] && !st[4])) m_reg = '0;
        else if (!st[3]) m_reg = bus;
        #1;
        data_sram_rdata = rdata_next;
        #1;
        ldata = m_held ? m_hold : data_sram_rdata;
        o1 = ref_out_slot(m_reg[143:0], 1'b1, ldata);
        o2 = ref_out_slot(m_reg[287:144], 1'b0, ldata);
        checkOutput("wb_bus", mem_to_wb_bus, {o2, o1});
        checkOutput("rf_bus", 272'(mem_to_rf_bus), 272'({o2[37:0], o1[37:0]}));
    endtask

    initial begin
        logic [143:0] ld_slot;
        logic [143:0] alu1;
        logic [143:0] alu2;
        logic [5:0]   st;

        rst = 1'b1; flush = 1'b0; stall = '0;
        ex_to_mem_bus = '0; data_sram_rdata = '0;
        m_reg = '0; m_held = 1'b0; m_hold = '0;

        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            applyStimulus({rand_slot(), rand_slot()}, 6'($urandom), 1'($urandom), 1'b1, $urandom);
            checkOutput("reset_wb", mem_to_wb_bus, '0);
            checkOutput("reset_rf", 272'(mem_to_rf_bus), '0);
        end

        // Byte/halfword extraction at 0x1002.
        ld_slot = make_slot('0, 32'h0000_0100, 1'b1, 4'h0, 3'b001, 1'b1, 5'd3, 32'h0000_1002);
        applyStimulus({rand_slot(), ld_slot}, 6'h00, 1'b0, 1'b0, 32'h12F4_5678);
        checkOutput("lb", 272'(mem_to_rf_bus[31:0]), 272'(32'hFFFF_FFF4));
        ld_slot[40:38] = 3'b010;
        applyStimulus({rand_slot(), ld_slot}, 6'h00, 1'b0, 1'b0, 32'h12F4_5678);
        checkOutput("lbu", 272'(mem_to_rf_bus[31:0]), 272'(32'h0000_00F4));
        ld_slot[40:38] = 3'b100;
        applyStimulus({rand_slot(), ld_slot}, 6'h00, 1'b0, 1'b0, 32'h12F4_5678);
        checkOutput("lhu", 272'(mem_to_rf_bus[31:0]), 272'(32'h0000_12F4));

        // A stalled lw keeps the first data word while the SRAM moves on.
        ld_slot = make_slot('0, 32'h0000_0200, 1'b1, 4'h0, 3'b000, 1'b1, 5'd7, 32'h0000_2000);
        applyStimulus({rand_slot(), ld_slot}, 6'h00, 1'b0, 1'b0, 32'hCAFE_BABE);
        checkOutput("lw_live", 272'(mem_to_rf_bus[31:0]), 272'(32'hCAFE_BABE));
        for (int i = 0; i < 3; i++) begin
            applyStimulus({rand_slot(), rand_slot()}, 6'b011000, 1'b0, 1'b0, 32'hDEAD_BEEF);
            checkOutput("lw_held", 272'(mem_to_rf_bus[31:0]), 272'(32'hCAFE_BABE));
        end
        applyStimulus({rand_slot(), rand_slot()}, 6'h00, 1'b0, 1'b0, $urandom);

        // Bubble, then flush over a valid bundle.
        alu1 = make_slot({2'b11, 64'h1}, 32'h0000_0300, 1'b0, 4'h0, 3'b000, 1'b1, 5'd9, 32'h55);
        alu2 = make_slot({2'b11, 64'h2}, 32'h0000_0304, 1'b0, 4'h0, 3'b000, 1'b1, 5'd10, 32'h66);
        applyStimulus({alu2, alu1}, 6'b001000, 1'b0, 1'b0, $urandom);
        checkOutput("bubble", mem_to_wb_bus, '0);
        applyStimulus({alu2, alu1}, 6'b011000, 1'b1, 1'b0, $urandom);
        checkOutput("flush", 272'(mem_to_rf_bus), '0);

        // Both slots write $5; both forwarded, i2 in the upper half.
        alu1 = make_slot('0, 32'h0000_0400, 1'b0, 4'h0, 3'b000, 1'b1, 5'd5, 32'd1);
        alu2 = make_slot('0, 32'h0000_0404, 1'b0, 4'h0, 3'b000, 1'b1, 5'd5, 32'd2);
        applyStimulus({alu2, alu1}, 6'h00, 1'b0, 1'b0, $urandom);
        checkOutput("dual_fwd", 272'(mem_to_rf_bus),
                    272'({1'b1, 5'd5, 32'd2, 1'b1, 5'd5, 32'd1}));
        checkOutput("dual_pc", 272'({mem_to_wb_bus[205:174], mem_to_wb_bus[69:38]}),
                    272'({32'h0000_0404, 32'h0000_0400}));

        // Randomized traffic with mixed stalls, flushes and occasional reset.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       st = 6'b000000;
                1:       st = 6'b001000;
                2:       st = 6'b011000;
                default: st = 6'($urandom);
            endcase
            applyStimulus({rand_slot(), rand_slot()}, st, ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 63) == 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
